// File: rtl/p4_split_pkg.sv
// Shared types and helpers for the P4 packet split/forward path.
// Descriptor packing order is {err, len, port}, MSB first.
package p4_split_pkg;

  localparam int META_PORT_W = 9;
  localparam int LEN_W       = 16;
  localparam int MAX_KEEP_W  = 128;

  typedef struct packed {
    logic                   err;
    logic [LEN_W-1:0]       len;
    logic [META_PORT_W-1:0] port;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  // Counts set bits of a byte-enable mask, zero-extended to MAX_KEEP_W.
  function automatic logic [7:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (keep[i]) cnt++;
    end
    return 8'(cnt);
  endfunction

  // True when the mask is a run of ones starting at bit 0 (all-zero included).
  function automatic logic keep_contig(input logic [MAX_KEEP_W-1:0] keep);
    return (keep & (keep + MAX_KEEP_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/p4_desc_fifo.sv
// Registered first-word-fall-through FIFO with an occupancy count output.
// DEPTH must be a power of two; pointers wrap naturally.
module p4_desc_fifo #(
  parameter  int WIDTH = 26,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & (count != CW'(DEPTH));
  assign do_pop   = pop & (count != '0);
  assign valid    = (count != '0);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the read side is gated by valid, so stale
  // contents are never visible and the array can map onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/p4_axis_rx_sink.sv
// Receive endpoint for the P4 pipeline: turns each AXI-Stream packet plus its
// metadata into a {err, len, port} descriptor queued for downstream logic.
module p4_axis_rx_sink
  import p4_split_pkg::*;
#(
  parameter int TDATA_NUM_BYTES      = 64,
  parameter int USER_META_DATA_WIDTH = 9,
  parameter int LEN_WIDTH            = 16,
  parameter int DESC_DEPTH           = 4
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [TDATA_NUM_BYTES*8-1:0]    s_axis_tdata,
  input  logic [TDATA_NUM_BYTES-1:0]      s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
  input  logic                            user_metadata_in_valid,
  output logic [USER_META_DATA_WIDTH-1:0] m_desc_port,
  output logic [LEN_WIDTH-1:0]            m_desc_len,
  output logic                            m_desc_err,
  output logic                            m_desc_valid,
  input  logic                            m_desc_ready,
  output logic [31:0]                     pkt_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;
  localparam int FIFO_W = 1 + LEN_WIDTH + USER_META_DATA_WIDTH;
  localparam int CNT_W  = $clog2(DESC_DEPTH) + 1;
  localparam logic [TDATA_NUM_BYTES-1:0] KEEP_ALL = '1;

  logic [0:0]                      state;
  logic [0:0]                      state_next;
  logic                            rst_done;
  logic [LEN_WIDTH:0]              len_acc;
  logic [LEN_WIDTH:0]              len_next;
  logic [LEN_WIDTH+1:0]            len_sum;
  logic                            err_acc;
  logic                            err_next;
  logic                            meta_seen;
  logic [USER_META_DATA_WIDTH-1:0] meta_reg;
  logic                            meta_take;
  logic                            beat_ok;
  logic                            beat_err;
  logic                            push;
  logic [7:0]                      beat_bytes;
  logic [USER_META_DATA_WIDTH-1:0] desc_port;
  logic [LEN_WIDTH-1:0]            desc_len;
  logic                            desc_err;
  logic [FIFO_W-1:0]               desc_word;
  logic [FIFO_W-1:0]               pop_word;
  logic [CNT_W-1:0]                fifo_count;
  logic                            unused_tdata;

  assign unused_tdata = ^s_axis_tdata;

  // Full is decoded from the registered count only, so m_desc_ready never
  // reaches tready combinationally.
  assign s_axis_tready = rst_done & (fifo_count != CNT_W'(DESC_DEPTH));
  assign beat_ok       = s_axis_tvalid & s_axis_tready;
  assign push          = beat_ok & s_axis_tlast;
  assign meta_take     = user_metadata_in_valid & ~meta_seen;
  assign beat_bytes    = popcount(MAX_KEEP_W'(s_axis_tkeep));

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    beat_err  = 1'b0;
    len_sum   = '0;
    len_next  = len_acc;
    err_next  = err_acc;
    desc_port = '0;
    desc_len  = '0;
    desc_err  = 1'b0;

    beat_err = ~keep_contig(MAX_KEEP_W'(s_axis_tkeep))
             | (~s_axis_tlast & (s_axis_tkeep != KEEP_ALL));

    // Bit LEN_WIDTH of len_acc acts as a sticky overflow marker.
    len_sum = {1'b0, len_acc} + (LEN_WIDTH+2)'(beat_bytes);
    if (beat_ok) begin
      len_next = (|len_sum[LEN_WIDTH+1:LEN_WIDTH])
               ? {1'b1, {LEN_WIDTH{1'b0}}} : len_sum[LEN_WIDTH:0];
    end

    err_next = err_acc | (user_metadata_in_valid & meta_seen)
             | (beat_ok & (beat_err | len_next[LEN_WIDTH]));

    desc_port = meta_seen ? meta_reg
              : (user_metadata_in_valid ? user_metadata_in : '0);
    desc_len  = len_next[LEN_WIDTH] ? '1 : len_next[LEN_WIDTH-1:0];
    desc_err  = err_next | ~(meta_seen | user_metadata_in_valid);
  end

  assign desc_word = {desc_err, desc_len, desc_port};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (beat_ok && !s_axis_tlast) state_next = ST_BODY;
      ST_BODY: if (beat_ok && s_axis_tlast)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      len_acc   <= '0;
      err_acc   <= 1'b0;
      meta_seen <= 1'b0;
      meta_reg  <= '0;
      pkt_count <= '0;
    end else begin
      state    <= state_next;
      rst_done <= 1'b1;
      if (push) begin
        len_acc   <= '0;
        err_acc   <= 1'b0;
        meta_seen <= 1'b0;
        pkt_count <= pkt_count + 32'd1;
      end else begin
        len_acc <= len_next;
        err_acc <= err_next;
        if (meta_take) begin
          meta_seen <= 1'b1;
          meta_reg  <= user_metadata_in;
        end
      end
    end
  end

  p4_desc_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_aresetn),
    .push      (push),
    .push_data (desc_word),
    .pop       (m_desc_valid & m_desc_ready),
    .pop_data  (pop_word),
    .valid     (m_desc_valid),
    .count     (fifo_count)
  );

  assign {m_desc_err, m_desc_len, m_desc_port} = pop_word;

endmodule
